// File: rtl/qdiv.sv
// rtl/qdiv.sv - sign-magnitude fixed-point divider, restoring shift-subtract, one quotient bit per clock
// Quotient magnitude is floor((|dividend| << Q) / |divisor|); bits above N-2 raise o_overflow.
module qdiv #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_start,
  output logic [N-1:0] o_quotient_out,
  output logic         o_complete,
  output logic         o_overflow
);

  localparam int IT = N + Q - 1;       // iterations == full magnitude result width
  localparam int DW = 2 * N + Q - 3;   // divisor magnitude pre-shifted to bit IT-1
  localparam int CW = $clog2(IT + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_load;
  logic [IT-1:0]   r_rem;
  logic [IT-1:0]   r_quo;
  logic [DW-1:0]   r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            w_ge;
  logic            w_last;
  logic [IT-1:0]   w_quo_next;

  // A zero divisor compares as <= every remainder, so all quotient bits set on their own.
  assign w_ge       = ({{(DW-IT){1'b0}}, r_rem} >= r_div);
  assign w_quo_next = {r_quo[IT-2:0], w_ge};
  assign w_last     = (r_cnt == CW'(1));
  assign o_complete = (r_state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_BUSY;
          w_load = 1'b1;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem          <= '0;
      r_quo          <= '0;
      r_div          <= '0;
      r_cnt          <= '0;
      r_sign         <= 1'b0;
      o_quotient_out <= '0;
      o_overflow     <= 1'b0;
    end else if (w_load) begin
      r_rem      <= {i_dividend[N-2:0], {Q{1'b0}}};
      r_div      <= {i_divisor[N-2:0], {(IT-1){1'b0}}};
      r_quo      <= '0;
      r_cnt      <= CW'(IT);
      r_sign     <= i_dividend[N-1] ^ i_divisor[N-1];
      o_overflow <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_quo <= w_quo_next;
      if (w_ge) begin
        r_rem <= r_rem - r_div[IT-1:0];
      end
      r_div <= r_div >> 1;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        o_quotient_out <= {r_sign, w_quo_next[N-2:0]};
        o_overflow     <= |w_quo_next[IT-1:N-1];
      end
    end
  end

endmodule

// File: tb/tb_qdiv.sv
// tb/tb_qdiv.sv - randomized self-checking bench for qdiv against an arithmetic reference model
module tb_qdiv;
  localparam int Q = 15;
  localparam int N = 32;
  localparam int IT = N + Q - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         start = 1'b0;
  logic [N-1:0] quotient;
  logic         complete;
  logic         overflow;

  int total = 0;
  int bad = 0;

  // reference model state
  bit           m_busy = 1'b0;
  int           m_cnt = 0;
  logic [N-1:0] m_q = '0;
  logic         m_ovf = 1'b0;
  logic [N-1:0] m_pend_q = '0;
  logic         m_pend_ovf = 1'b0;

  qdiv #(.Q(Q), .N(N)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_dividend     (dividend),
    .i_divisor      (divisor),
    .i_start        (start),
    .o_quotient_out (quotient),
    .o_complete     (complete),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic [N-1:0] dd, input logic [N-1:0] dv,
                                  output logic [N-1:0] q, output logic o);
    longint unsigned a, b, r, mask;
    mask = (64'd1 << IT) - 64'd1;
    a = longint'(dd[N-2:0]) << Q;
    b = longint'(dv[N-2:0]);
    r = (b == 0) ? mask : (a / b);
    q = {dd[N-1] ^ dv[N-1], r[N-2:0]};
    o = ((r >> (N - 1)) != 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_q    = '0;
      m_ovf  = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_cnt  = IT;
        m_ovf  = 1'b0;
        ref_div(dividend, divisor, m_pend_q, m_pend_ovf);
      end
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_q    = m_pend_q;
        m_ovf  = m_pend_ovf;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("complete", 64'(complete), 64'(!m_busy));
    check("quotient", 64'(quotient), 64'(m_q));
    check("overflow", 64'(overflow), 64'(m_ovf));
  end

  // Called at posedge+#1; the start is sampled on the very next edge.
  task automatic do_div(input logic [N-1:0] dd, input logic [N-1:0] dv, input bit lit,
                        input logic [N-1:0] eq, input logic eo);
    int n;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n = 0;
    while (!complete && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(IT));
    if (lit) begin
      check("lit_quotient", 64'(quotient), 64'(eq));
      check("lit_overflow", 64'(overflow), 64'(eo));
    end
  endtask

  initial begin
    logic [N-1:0] dd, dv;
    #3;
    check("rst_complete", 64'(complete), 64'd1);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_div(32'h0000_8000, 32'h0000_8000, 1'b1, 32'h0000_8000, 1'b0);
    do_div(32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_8000, 1'b0);
    do_div(32'h8001_8000, 32'h0001_0000, 1'b1, 32'h8000_C000, 1'b0);
    do_div(32'h4000_0000, 32'h0000_4000, 1'b1, 32'h0000_0000, 1'b1);
    do_div(32'h0000_8000, 32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
    do_div(32'h8000_0000, 32'h0000_1234, 1'b1, 32'h8000_0000, 1'b0);
    do_div(32'h0000_0000, 32'h8000_0003, 1'b1, 32'h8000_0000, 1'b0);

    // second start mid-run is ignored
    dividend = 32'h0000_8000;
    divisor  = 32'h0001_0000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    dividend = 32'h0000_0001;
    divisor  = 32'h8000_0007;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (complete) break;
    end
    check("ignored_start_quotient", 64'(quotient), 64'h0000_4000);
    check("ignored_start_complete", 64'(complete), 64'd1);

    // asynchronous reset mid-run
    dividend = 32'h0012_3456;
    divisor  = 32'h0000_0789;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_complete", 64'(complete), 64'd1);
    check("async_rst_quotient", 64'(quotient), 64'd0);
    check("async_rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_div(32'h0001_8000, 32'h8000_8000, 1'b1, 32'h8001_8000, 1'b0);

    for (int i = 0; i < 30; i++) begin
      dd = $urandom;
      case ($urandom_range(0, 4))
        0: dv = {$urandom_range(0, 1) == 1, 31'd0};
        1: dv = {1'($urandom_range(0, 1)), 31'($urandom_range(1, 255))};
        2: dd = {1'($urandom_range(0, 1)), 31'd0};
        default: dv = $urandom;
      endcase
      if (i % 5 == 4) dv = $urandom;
      do_div(dd, dv, 1'b0, '0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
